cook_sequencer: RTL
===================

COOK_SEQUENCER -- requirements
Module: cook_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clock cycles per cook second (prescaler terminal count).
REQ-002 Parameter PWR_WINDOW, default 10, duty-cycle window length in seconds.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 key_valid  input  1  one-cycle strobe, key_digit is valid.
REQ-006 key_digit  input  4  BCD keypad digit; values 10-15 are ignored.
REQ-007 startn, stopn, clearn  input  1 each  active-low panel buttons, synchronous levels.
REQ-008 door_closed  input  1  high = door latched shut.
REQ-009 power_lvl  input  4  power level 0-10; values above 10 are treated as 10.
REQ-010 mag_on  output  1  magnetron enable (registered).
REQ-011 timer_done  output  1  cook complete, held until acknowledged.
REQ-012 time_bcd  output  16  remaining/entered time MM:SS, 4 BCD digits, [15:12] = minute tens.
REQ-013 state  output  3  current FSM state code.

Function
REQ-014 Buttons are edge-detected internally: an action fires on the first cycle a button is sampled low after being high; holding a button fires once.
REQ-015 FSM states: IDLE, ENTRY, COOK, PAUSE, DONE.
REQ-016 Event priority within one cycle: clear > door open > stop > start > key_valid.
REQ-017 Clear press in any state: go to IDLE, time_bcd = 0, timer_done = 0, mag_on = 0, next cycle.
REQ-018 IDLE/ENTRY, valid digit 0-9: time_bcd shifts left one digit, new digit enters [3:0], old [15:12] is discarded; IDLE moves to ENTRY.
REQ-019 key_valid in COOK or PAUSE is ignored; key_valid in DONE clears timer_done, then runs REQ-018 from IDLE.
REQ-020 Start in ENTRY or PAUSE goes to COOK only if door_closed = 1, time_bcd != 0 and seconds tens digit <= 5; otherwise it is ignored.
REQ-021 On entry to COOK, the prescaler and the duty-window second counter are reset to 0.
REQ-022 In COOK, the prescaler counts 0..CLK_HZ-1; on wrap it emits a one-cycle tick that decrements time_bcd by one second in BCD: SS 00 borrows from MM and becomes 59; digits never leave 0-9.
REQ-023 A tick that brings time_bcd to 00:00 moves to DONE on that same edge: mag_on = 0 and timer_done = 1 from the next cycle.
REQ-024 Door open in COOK goes to PAUSE. Stop in COOK goes to PAUSE. Prescaler and time_bcd hold in PAUSE.
REQ-025 Stop in PAUSE or ENTRY goes to IDLE with time_bcd = 0. Stop in DONE clears timer_done and goes to IDLE.
REQ-026 Door open in DONE clears timer_done and goes to IDLE.
REQ-027 Duty cycle: a window counter counts seconds 0..PWR_WINDOW-1 in COOK.
REQ-028 mag_on = 1 in COOK only while window count < power_lvl (clamped to 10); power 10 = continuous, power 0 = never on, with the timer still running.
REQ-029 mag_on is 0 in every state other than COOK, and is forced to 0 in the same cycle door_closed is sampled low (combinational gate on the registered enable).
REQ-030 Maximum time is 99:59; entry wraps digits out per REQ-018, with no saturation logic.

Reset
REQ-031 resetn low asynchronously sets state = IDLE, time_bcd = 0, mag_on = 0, timer_done = 0, prescaler = 0, window counter = 0, and button edge registers = released (high).
REQ-032 Reset asserted mid-COOK drops mag_on immediately, without waiting for a clock edge.

Structure
REQ-033 A shared package holds the FSM state encoding, the BCD digit width and the maximum power level constant 10.
REQ-034 One sub-module, bcd_down_counter (4-digit MM:SS, load/shift-in/decrement, zero flag), is instantiated once.
REQ-035 Prescaler, window counter, edge detectors and FSM are in the top module.

Verification (CLK_HZ = 4, PWR_WINDOW = 10)
REQ-036 Keys 0,0,0,3 then start, door closed, power 10 -> COOK, mag_on = 1; time_bcd reads 0003, 0002, 0001, 0000 at 4-cycle ticks; DONE and timer_done = 1.
REQ-037 Time 00:12, power 3 -> mag_on high for seconds 0-2 of each window, low for seconds 3-9; pattern restarts at the second window.
REQ-038 Time 01:00, one tick -> time_bcd = 0059 (borrow); time 10:00 -> 0959.
REQ-039 Door opened mid-COOK at 00:05 -> mag_on 0 in the same cycle, PAUSE, time held; door closed then start -> resumes from 00:05.
REQ-040 Start with 00:00 or 00:75 -> stays in ENTRY, mag_on = 0.
REQ-041 Clear and start pressed in the same cycle during PAUSE -> IDLE, time 0; resetn pulsed mid-COOK -> mag_on 0 asynchronously, all outputs at reset values.

Source files
------------

// File: rtl/cook_sequencer_pkg.sv
// rtl/cook_sequencer_pkg.sv - shared types and constants for the cook sequencer
// Purpose: FSM state encoding, BCD digit/time widths, power clamp helper.
// Ports: none (package).
package cook_sequencer_pkg;

  localparam int DIGIT_W = 4;
  localparam int TIME_W  = 4 * DIGIT_W;

  localparam logic [DIGIT_W-1:0] MAX_POWER = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [DIGIT_W-1:0] clamp_power(input logic [DIGIT_W-1:0] lvl);
    return (lvl > MAX_POWER) ? MAX_POWER : lvl;
  endfunction

endpackage

// File: rtl/cook_sequencer_if.sv
// rtl/cook_sequencer_if.sv - panel/status bundle between the control panel and the sequencer
// Purpose: groups keypad, buttons, door, power inputs and status outputs.
// Ports: master = panel side (drives inputs, reads status); slave = sequencer side.
interface cook_sequencer_if;
  import cook_sequencer_pkg::*;

  logic               key_valid;
  logic [DIGIT_W-1:0] key_digit;
  logic               startn;
  logic               stopn;
  logic               clearn;
  logic               door_closed;
  logic [DIGIT_W-1:0] power_lvl;
  logic               mag_on;
  logic               timer_done;
  logic [TIME_W-1:0]  time_bcd;
  logic [2:0]         state;

  modport master (
    output key_valid, key_digit, startn, stopn, clearn, door_closed, power_lvl,
    input  mag_on, timer_done, time_bcd, state
  );

  modport slave (
    input  key_valid, key_digit, startn, stopn, clearn, door_closed, power_lvl,
    output mag_on, timer_done, time_bcd, state
  );

endinterface

// File: rtl/cook_sequencer_bcd_down_counter.sv
// rtl/cook_sequencer_bcd_down_counter.sv - 4-digit MM:SS BCD register with load, shift-in and decrement
// Purpose: holds entered/remaining time; seconds borrow from minutes (00 -> 59).
// Ports: clk, resetn (async low), load/load_value, shift_en/shift_digit, dec, value, zero.
module bcd_down_counter
  import cook_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic [TIME_W-1:0]  load_value,
  input  logic               shift_en,
  input  logic [DIGIT_W-1:0] shift_digit,
  input  logic               dec,
  output logic [TIME_W-1:0]  value,
  output logic               zero
);

  logic [TIME_W-1:0] cnt;
  logic [TIME_W-1:0] dec_value;

  // Ripple borrow through the digits; seconds tens wraps to 5, others to 9.
  always_comb begin
    dec_value = cnt;
    if (cnt[3:0] != 4'd0) begin
      dec_value[3:0] = cnt[3:0] - 4'd1;
    end else begin
      dec_value[3:0] = 4'd9;
      if (cnt[7:4] != 4'd0) begin
        dec_value[7:4] = cnt[7:4] - 4'd1;
      end else begin
        dec_value[7:4] = 4'd5;
        if (cnt[11:8] != 4'd0) begin
          dec_value[11:8] = cnt[11:8] - 4'd1;
        end else begin
          dec_value[11:8]  = 4'd9;
          dec_value[15:12] = cnt[15:12] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (shift_en) begin
      cnt <= {cnt[TIME_W-DIGIT_W-1:0], shift_digit};
    end else if (dec && !zero) begin
      cnt <= dec_value;
    end
  end

  assign value = cnt;
  assign zero  = (cnt == '0);

endmodule

// File: rtl/cook_sequencer.sv
// rtl/cook_sequencer.sv - microwave cook sequencer top: buttons, FSM, prescaler, duty window
// Purpose: time entry, countdown in one-second ticks, power duty cycling, door interlock.
// Ports: clk, resetn (async low), bus (cook_sequencer_if.slave: keypad/buttons/door/power in, mag_on/timer_done/time_bcd/state out).
module cook_sequencer
  import cook_sequencer_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int PWR_WINDOW = 10
) (
  input  logic                 clk,
  input  logic                 resetn,
  cook_sequencer_if.slave      bus
);

  localparam int PRESC_W = $clog2(CLK_HZ + 1);
  localparam int WIN_W   = $clog2(PWR_WINDOW + 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(PWR_WINDOW - 1);

  state_t             state, state_next;
  logic               start_q, stop_q, clear_q;
  logic [PRESC_W-1:0] presc;
  logic [WIN_W-1:0]   win, win_next;
  logic               mag_en, mag_en_next, done_q;
  logic [TIME_W-1:0]  time_bcd;
  logic               time_zero;

  logic start_ev, stop_ev, clear_ev, key_ok, door_evt;
  logic stop_act, start_act, key_act, start_ok, tick, last_sec;
  logic bcd_load, bcd_shift, bcd_dec, cook_entry, cook_stay;

  assign start_ev = start_q & ~bus.startn;
  assign stop_ev  = stop_q  & ~bus.stopn;
  assign clear_ev = clear_q & ~bus.clearn;
  assign key_ok   = bus.key_valid && (bus.key_digit <= 4'd9);

  // Door open only has an action in COOK and DONE, so it only outranks the
  // lower-priority events there; time entry with the door open still works.
  assign door_evt  = ~bus.door_closed && (state == ST_COOK || state == ST_DONE);
  assign stop_act  = !clear_ev && !door_evt && stop_ev;
  assign start_act = !clear_ev && !door_evt && !stop_ev && start_ev;
  assign key_act   = !clear_ev && !door_evt && !stop_ev && !start_ev && key_ok;

  assign start_ok = bus.door_closed && !time_zero && (time_bcd[7:4] <= 4'd5);
  assign tick     = (state == ST_COOK) && (presc == PRESC_LAST);
  assign last_sec = (time_bcd == TIME_W'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear_ev) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (key_act) state_next = ST_ENTRY;
        ST_ENTRY: begin
          if (stop_act)                   state_next = ST_IDLE;
          else if (start_act && start_ok) state_next = ST_COOK;
        end
        ST_COOK: begin
          if (door_evt || stop_act) state_next = ST_PAUSE;
          else if (tick && last_sec) state_next = ST_DONE;
        end
        ST_PAUSE: begin
          if (stop_act)                   state_next = ST_IDLE;
          else if (start_act && start_ok) state_next = ST_COOK;
        end
        ST_DONE: begin
          if (door_evt || stop_act) state_next = ST_IDLE;
          else if (key_act)         state_next = ST_ENTRY;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bcd_load   = clear_ev || (stop_act && (state == ST_ENTRY || state == ST_PAUSE));
    bcd_shift  = key_act && (state == ST_IDLE || state == ST_ENTRY || state == ST_DONE);
    cook_entry = (state != ST_COOK) && (state_next == ST_COOK);
    cook_stay  = (state == ST_COOK) && (state_next == ST_COOK);
    // The final tick leaves COOK for DONE but must still reach 00:00.
    bcd_dec    = tick && (state_next == ST_COOK || state_next == ST_DONE);
    win_next   = win;
    if (cook_entry)            win_next = '0;
    else if (cook_stay && tick) win_next = (win == WIN_LAST) ? '0 : win + 1'b1;
    mag_en_next = (state_next == ST_COOK) &&
                  (32'(win_next) < 32'(clamp_power(bus.power_lvl)));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_q <= 1'b1;
      stop_q  <= 1'b1;
      clear_q <= 1'b1;
      presc   <= '0;
      win     <= '0;
      mag_en  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= bus.startn;
      stop_q  <= bus.stopn;
      clear_q <= bus.clearn;
      if (cook_entry)     presc <= '0;
      else if (cook_stay) presc <= tick ? '0 : presc + 1'b1;
      win     <= win_next;
      mag_en  <= mag_en_next;
      done_q  <= (state_next == ST_DONE);
    end
  end

  bcd_down_counter u_time (
    .clk         (clk),
    .resetn      (resetn),
    .load        (bcd_load),
    .load_value  ({TIME_W{1'b0}}),
    .shift_en    (bcd_shift),
    .shift_digit (bus.key_digit),
    .dec         (bcd_dec),
    .value       (time_bcd),
    .zero        (time_zero)
  );

  // Door gate is combinational so an opening door cuts power without a clock edge.
  assign bus.mag_on     = mag_en & bus.door_closed;
  assign bus.timer_done = done_q;
  assign bus.time_bcd   = time_bcd;
  assign bus.state      = state;

endmodule
